// File: rtl/dmem_responder_pkg.sv
// Shared types and helpers for the data-memory responder: access-size codes,
// read-FSM state encoding and byte-lane helper functions.
package dmem_responder_pkg;

    localparam int ADDR_SIZE  = 31;
    localparam int INSTR_SIZE = 31;

    localparam logic [1:0] DMEM_SZ_BYTE = 2'b00;
    localparam logic [1:0] DMEM_SZ_HALF = 2'b01;
    localparam logic [1:0] DMEM_SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        DMEM_IDLE  = 2'd0,
        DMEM_WAIT  = 2'd1,
        DMEM_READY = 2'd2
    } dmem_state_e;

    function automatic logic [3:0] lane_enables(input logic [1:0] size, input logic [1:0] lane);
        logic [3:0] be;
        case (size)
            DMEM_SZ_BYTE: be = 4'b0001 << lane;
            DMEM_SZ_HALF: be = lane[1] ? 4'b1100 : 4'b0011;
            DMEM_SZ_WORD: be = 4'b1111;
            default:      be = 4'b0000;
        endcase
        return be;
    endfunction

    // Copy the right-justified store data into every lane it could land in.
    function automatic logic [31:0] replicate_lanes(input logic [1:0] size, input logic [31:0] data);
        logic [31:0] word;
        case (size)
            DMEM_SZ_BYTE: word = {4{data[7:0]}};
            DMEM_SZ_HALF: word = {2{data[15:0]}};
            default:      word = data;
        endcase
        return word;
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
        logic mis;
        case (size)
            DMEM_SZ_HALF: mis = lane[0];
            DMEM_SZ_WORD: mis = (lane != 2'b00);
            default:      mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// DEPTH_WORDS x 32 storage with a byte-enabled synchronous write port and an
// asynchronous read port; contents are never reset.
module dmem_array #(
    parameter int DEPTH_WORDS = 1024,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [3:0]       wr_be,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [31:0]      wr_data,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [31:0]      rd_data
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (wr_en && wr_be[b]) begin
                mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
            end
        end
    end

    assign rd_data = mem[rd_idx];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory slave: zero-wait byte/half/word stores, loads returned after
// RD_LATENCY cycles. Optional macro DMEM_ALIGN_CHECK_EN adds misalignment reporting.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int RD_LATENCY  = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ADDR_SIZE:0]  mem_addr,
    input  logic [INSTR_SIZE:0] mem_wr_data,
    input  logic                mem_wr_enable,
    input  logic [1:0]          mem_wr_size,
    input  logic                mem_rd_enable,
    output logic [INSTR_SIZE:0] mem_rd_data,
`ifdef DMEM_ALIGN_CHECK_EN
    output logic                mem_misaligned,
`endif
    output logic                mem_rd_ready
);

    localparam int         IDX_W    = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_INIT = 4'(RD_LATENCY - 1);

    dmem_state_e      state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q;
    logic [1:0]       lane_q;
    logic             latch_en;
    logic             capture;

    logic [1:0]       wr_lane;
    logic [3:0]       wr_be;
    logic [31:0]      wr_word;
    logic             wr_commit;

    logic [IDX_W-1:0] rd_idx;
    logic [1:0]       rd_lane;
    logic [31:0]      rd_word;
    logic [31:0]      rd_shifted;
    logic [31:0]      rd_load_data;
    logic             unused_addr_bits;

    assign unused_addr_bits = ^mem_addr[ADDR_SIZE:IDX_W+2];

    assign wr_lane = mem_addr[1:0];
    assign wr_be   = lane_enables(mem_wr_size, wr_lane);
    assign wr_word = replicate_lanes(mem_wr_size, mem_wr_data);

    // With RD_LATENCY==1 the capture happens from IDLE, so it must use the live address.
    assign rd_idx     = (state_q == DMEM_IDLE) ? mem_addr[IDX_W+1:2] : idx_q;
    assign rd_lane    = (state_q == DMEM_IDLE) ? mem_addr[1:0]       : lane_q;
    assign rd_shifted = rd_word >> {rd_lane, 3'b000};

`ifdef DMEM_ALIGN_CHECK_EN
    logic [1:0] size_q;
    logic [1:0] rd_size;
    logic       store_misaligned;
    logic       load_misaligned;

    // Loads carry no size of their own; the initiator drives the access size on mem_wr_size.
    assign rd_size          = (state_q == DMEM_IDLE) ? mem_wr_size : size_q;
    assign store_misaligned = is_misaligned(mem_wr_size, wr_lane);
    assign load_misaligned  = is_misaligned(rd_size, rd_lane);
    assign wr_commit        = mem_wr_enable && !store_misaligned;
    assign rd_load_data     = load_misaligned ? 32'd0 : rd_shifted;

    always_ff @(posedge clk) begin
        if (!reset) begin
            mem_misaligned <= 1'b0;
        end else begin
            mem_misaligned <= (mem_wr_enable && store_misaligned) || (capture && load_misaligned);
        end
    end

    always_ff @(posedge clk) begin
        if (latch_en) begin
            size_q <= mem_wr_size;
        end
    end
`else
    assign wr_commit    = mem_wr_enable;
    assign rd_load_data = rd_shifted;
`endif

    dmem_array #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .IDX_W      (IDX_W)
    ) u_array (
        .clk    (clk),
        .wr_en  (wr_commit),
        .wr_be  (wr_be),
        .wr_idx (mem_addr[IDX_W+1:2]),
        .wr_data(wr_word),
        .rd_idx (rd_idx),
        .rd_data(rd_word)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        latch_en = 1'b0;
        capture  = 1'b0;
        case (state_q)
            DMEM_IDLE: begin
                if (mem_rd_enable) begin
                    latch_en = 1'b1;
                    cnt_d    = CNT_INIT;
                    if (RD_LATENCY == 1) begin
                        capture = 1'b1;
                        state_d = DMEM_READY;
                    end else begin
                        state_d = DMEM_WAIT;
                    end
                end
            end
            DMEM_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    capture = 1'b1;
                    state_d = DMEM_READY;
                end
            end
            DMEM_READY: state_d = DMEM_IDLE;
            default:    state_d = DMEM_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= DMEM_IDLE;
            cnt_q       <= 4'd0;
            mem_rd_data <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (capture) begin
                mem_rd_data <= rd_load_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (latch_en) begin
            idx_q  <= mem_addr[IDX_W+1:2];
            lane_q <= mem_addr[1:0];
        end
    end

    assign mem_rd_ready = (state_q == DMEM_READY);

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder (DEPTH_WORDS=1024, RD_LATENCY=2).
module tb_dmem_responder;
    import dmem_responder_pkg::*;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] mem_addr;
    logic [31:0] mem_wr_data;
    logic        mem_wr_enable;
    logic [1:0]  mem_wr_size;
    logic        mem_rd_enable;
    logic [31:0] mem_rd_data;
    logic        mem_rd_ready;
`ifdef DMEM_ALIGN_CHECK_EN
    logic        mem_misaligned;
`endif

    int checks = 0;
    int passes = 0;
    int cyc    = 0;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;
    exp_t sb[$];

    dmem_responder #(
        .DEPTH_WORDS(1024),
        .RD_LATENCY (LAT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .mem_addr     (mem_addr),
        .mem_wr_data  (mem_wr_data),
        .mem_wr_enable(mem_wr_enable),
        .mem_wr_size  (mem_wr_size),
        .mem_rd_enable(mem_rd_enable),
        .mem_rd_data  (mem_rd_data),
`ifdef DMEM_ALIGN_CHECK_EN
        .mem_misaligned(mem_misaligned),
`endif
        .mem_rd_ready (mem_rd_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor: every ready pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (mem_rd_ready) begin
            check("ready_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                check("rd_data", mem_rd_data, e.data);
                check("ready_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    task automatic push(input logic [31:0] d, input int c);
        exp_t e;
        e.data = d;
        e.cyc  = c;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
        mem_addr      = a;
        mem_wr_data   = d;
        mem_wr_size   = sz;
        mem_wr_enable = 1'b1;
        tick();
        mem_wr_enable = 1'b0;
    endtask

    task automatic load(input logic [31:0] a, input logic [31:0] exp);
        mem_addr      = a;
        mem_rd_enable = 1'b1;
        push(exp, cyc + LAT);
        repeat (LAT) tick();
        mem_rd_enable = 1'b0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset         = 1'b0;
        mem_addr      = '0;
        mem_wr_data   = '0;
        mem_wr_enable = 1'b0;
        mem_wr_size   = DMEM_SZ_WORD;
        mem_rd_enable = 1'b0;
        repeat (3) tick();
        check("reset_ready", {31'd0, mem_rd_ready}, 32'd0);
        check("reset_data", mem_rd_data, 32'd0);
        reset = 1'b1;
        tick();

        // Word store then load with exact latency.
        store(32'h100, 32'hDEADBEEF, DMEM_SZ_WORD);
        load(32'h100, 32'hDEADBEEF);

        // Reset while in WAIT: no ready pulse, data cleared.
        mem_addr      = 32'h100;
        mem_rd_enable = 1'b1;
        tick();
        reset         = 1'b0;
        mem_rd_enable = 1'b0;
        tick();
        reset = 1'b1;
        check("midread_data", mem_rd_data, 32'd0);
        check("midread_ready", {31'd0, mem_rd_ready}, 32'd0);
        repeat (3) tick();
        check("post_reset_data", mem_rd_data, 32'd0);
        load(32'h100, 32'hDEADBEEF);

        // Byte and half stores into a cleared word.
        store(32'h100, 32'h00000000, DMEM_SZ_WORD);
        store(32'h103, 32'h123456AA, DMEM_SZ_BYTE);
        store(32'h100, 32'hFFFF1234, DMEM_SZ_HALF);
        load(32'h103, 32'h000000AA);
        load(32'h100, 32'hAA001234);
        load(32'h102, 32'h0000AA00);

        // Reserved size writes nothing.
        store(32'h100, 32'hFFFFFFFF, 2'b11);
        load(32'h100, 32'hAA001234);

        // Force-aligned half and word stores.
        store(32'h104, 32'h00000000, DMEM_SZ_WORD);
        store(32'h105, 32'h00005678, DMEM_SZ_HALF);
        load(32'h104, 32'h00005678);
        store(32'h10A, 32'h9ABCDEF0, DMEM_SZ_WORD);
        load(32'h108, 32'h9ABCDEF0);
        load(32'h109, 32'h009ABCDE);

        // Back-to-back loads with enable held high.
        store(32'h0, 32'h01020304, DMEM_SZ_WORD);
        store(32'h4, 32'h05060708, DMEM_SZ_WORD);
        mem_addr      = 32'h0;
        mem_rd_enable = 1'b1;
        push(32'h01020304, cyc + LAT);
        repeat (LAT) tick();
        mem_addr = 32'h4;
        push(32'h05060708, cyc + LAT + 1);
        repeat (LAT + 1) tick();
        mem_rd_enable = 1'b0;
        tick();

        // Upper address bits ignored.
        store(32'h1000, 32'hCAFEF00D, DMEM_SZ_WORD);
        load(32'h0, 32'hCAFEF00D);
        load(32'h4000, 32'hCAFEF00D);

        // Store on the capture edge: old data first, new data on the repeat.
        store(32'h200, 32'h11111111, DMEM_SZ_WORD);
        mem_addr      = 32'h200;
        mem_rd_enable = 1'b1;
        push(32'h11111111, cyc + LAT);
        tick();
        mem_wr_data   = 32'h22222222;
        mem_wr_size   = DMEM_SZ_WORD;
        mem_wr_enable = 1'b1;
        tick();
        mem_wr_enable = 1'b0;
        mem_rd_enable = 1'b0;
        tick();
        load(32'h200, 32'h22222222);

        repeat (4) tick();
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory slave on the far end of the memory stage's dmem interface.
- Accepts byte/half/word stores with zero wait states.
- Serves loads with a programmable number of wait states, then pulses mem_rd_ready with the addressed bytes right-justified in mem_rd_data.
- Sits beside the pipeline in the core top level as the sole dmem target.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words in the array (power of two).
- RD_LATENCY, 2, cycles from read acceptance to mem_rd_ready (legal range 1..15).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
- mem_addr  input  `ADDR_SIZE+1  byte address.
- mem_wr_data  input  `INSTR_SIZE+1  store data, right-justified.
- mem_wr_enable  input  1  store request, one cycle per store.
- mem_wr_size  input  2  00 byte, 01 half, 10 word, 11 reserved (no write).
- mem_rd_enable  input  1  load request, held high by initiator until mem_rd_ready.
- mem_rd_data  output  `INSTR_SIZE+1  load data, right-justified, registered.
- mem_rd_ready  output  1  one-cycle pulse; mem_rd_data valid in the same cycle.

Behaviour:
- Reset (reset==0 at an edge):
  - State goes to IDLE; wait counter cleared.
  - mem_rd_ready=0, mem_rd_data=0.
  - Array contents untouched.
  - Reset mid-read aborts the read; no ready pulse is issued for it.
- Indexing:
  - Word index = mem_addr[log2(DEPTH_WORDS)+1:2].
  - Upper address bits are ignored, so accesses wrap modulo the array size.
  - Byte lane = mem_addr[1:0].
- Writes:
  - Committed at the edge where mem_wr_enable==1, independent of the read FSM.
  - Byte: lane = mem_addr[1:0], data = wr_data[7:0].
  - Half: lanes {a[1],0}+{0,1}, data = wr_data[15:0]; mem_addr[0] is ignored.
  - Word: all four lanes; mem_addr[1:0] is ignored.
  - Size 11: no lanes written.
- Read FSM states: IDLE, WAIT, READY.
  - IDLE: if mem_rd_enable==1, latch mem_addr, load counter=RD_LATENCY-1. Go to READY if RD_LATENCY==1, else WAIT.
  - WAIT: decrement the counter. When it reaches 0, capture the array word into mem_rd_data (shifted right by 8*lane) and go to READY.
  - READY: mem_rd_ready=1 for exactly this cycle, then go to IDLE. In this cycle mem_rd_data holds its value; it is held until the next capture.
  - For RD_LATENCY==1 the capture happens on the IDLE→READY edge.
- Timing:
  - A request first seen in IDLE during cycle c produces mem_rd_ready high in cycle c+RD_LATENCY.
  - A request still high in the cycle after READY is a new request (back-to-back loads).
  - Minimum spacing between ready pulses is RD_LATENCY+1 cycles.
- Read data is raw, not extended: zero-filled above the shifted bytes. Sign/zero extension is done by the memory stage.
- Address or mem_rd_enable changes during WAIT are ignored; the latched address is used.
- mem_rd_enable dropping during WAIT does not cancel the read; the ready pulse is still issued.
- Same-edge write and read capture to the same word: the read returns pre-write data. A write in any earlier cycle is visible.

Optional Feature:
- Macro: DMEM_ALIGN_CHECK_EN.
- When defined:
  - Adds output mem_misaligned (1 bit, reset 0).
  - Asserted for one cycle, registered, after any store with half and mem_addr[0]!=0, or word and mem_addr[1:0]!=0. Such stores are dropped.
  - On a misaligned load, mem_misaligned is asserted together with mem_rd_ready; mem_rd_data=0.
- When undefined:
  - No extra port.
  - Misaligned accesses are force-aligned as described in Behaviour.

Decomposition:
- Shared def_params.v gains:
  - `DMEM_SZ_BYTE/`DMEM_SZ_HALF/`DMEM_SZ_WORD (2'b00/01/10).
  - FSM state encodings `DMEM_IDLE/`DMEM_WAIT/`DMEM_READY.
- One natural sub-module, dmem_array:
  - DEPTH_WORDS×32 storage.
  - 4-bit byte-enable synchronous write port.
  - Asynchronous read port.
  - Lane/byte-enable and shift logic stay in dmem_responder.

Test Plan:
- Reset mid-read: assert reset in WAIT -> no mem_rd_ready pulse; mem_rd_data=0; next request completes normally.
- Word store 0xDEADBEEF @0x100, then load @0x100 with RD_LATENCY=2 -> mem_rd_ready exactly 2 cycles after request, data 0xDEADBEEF, single-cycle pulse.
- Byte store 0xAA @0x103, half store 0x1234 @0x100 -> loads: @0x103 byte returns 0x000000AA, @0x100 word returns 0xAA001234 (lane 2 unchanged from 0x00 init).
- Back-to-back loads @0x0 and @0x4 with mem_rd_enable held high -> two ready pulses 3 cycles apart (RD_LATENCY=2), correct data each.
- Wrap-around: DEPTH_WORDS=1024, store to 0x1000 -> load @0x0 returns the stored value.
- Same-edge store to the word being captured -> old value returned; repeat load -> new value. With DMEM_ALIGN_CHECK_EN: word store @0x102 -> mem_misaligned pulse, memory unchanged.
